// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the audio-codec configuration sequencer.
// Holds the sequencer state encoding, I2C word / table entry widths, the
// codec register-address map and the packed table entry layout.
package codec_cfg_pkg;

  localparam int unsigned I2C_WORD_W = 24;
  localparam int unsigned REG_ADDR_W = 7;
  localparam int unsigned REG_DATA_W = 9;
  localparam int unsigned ENTRY_W    = REG_ADDR_W + REG_DATA_W;

  // Codec register addresses
  localparam logic [REG_ADDR_W-1:0] REG_LLINE  = 7'h00;
  localparam logic [REG_ADDR_W-1:0] REG_RLINE  = 7'h01;
  localparam logic [REG_ADDR_W-1:0] REG_APATH  = 7'h04;
  localparam logic [REG_ADDR_W-1:0] REG_PDOWN  = 7'h06;
  localparam logic [REG_ADDR_W-1:0] REG_DAIF   = 7'h07;
  localparam logic [REG_ADDR_W-1:0] REG_ACTIVE = 7'h09;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT,
    RETRY,
    NEXT
  } state_t;

  // One table entry as it appears on the 16-bit tbl_entry bus
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/codec_cfg_rom.sv
// Default codec configuration table, indexed by the sequencer's tbl_idx.
// Ports:
//   idx     in  IDX_W  table index
//   entry_c out 16     {reg_addr[6:0], reg_data[8:0]}, combinational
// Order matters: power/path setup first, ACTIVE before the line-in gains.
module codec_cfg_rom
  import codec_cfg_pkg::*;
#(
  parameter int unsigned IDX_W = 8
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [ENTRY_W-1:0] entry_c
);

  cfg_entry_t entry;

  // Table lookup; unused indices read as zero
  always_comb begin
    entry = '{addr: '0, data: '0};
    case (idx)
      IDX_W'(0): entry = '{addr: REG_APATH,  data: 9'h004};
      IDX_W'(1): entry = '{addr: REG_DAIF,   data: 9'h042};
      IDX_W'(2): entry = '{addr: REG_ACTIVE, data: 9'h001};
      IDX_W'(3): entry = '{addr: REG_PDOWN,  data: 9'h039};
      IDX_W'(4): entry = '{addr: REG_LLINE,  data: 9'h017};
      IDX_W'(5): entry = '{addr: REG_RLINE,  data: 9'h017};
      default:   entry = '{addr: '0, data: '0};
    endcase
  end

  assign entry_c = entry;

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Audio-codec configuration sequencer. Walks a NUM_REGS-entry register
// table, issuing one 24-bit I2C write per entry through a start/done
// handshake, retrying NACKed writes up to MAX_RETRIES extra times.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   start       single-cycle (re)run request, ignored while busy
//   tbl_idx     table entry being addressed
//   tbl_entry   {reg_addr, reg_data} for tbl_idx
//   i2c_start   single-cycle transfer launch pulse
//   i2c_data    {DEV_ADDR, tbl_entry}, stable until i2c_done
//   i2c_done    transfer-complete pulse, i2c_ack qualifies it
//   busy/ready/error  run status; ready and error hold until next start
//   nack_count  saturating NACK count since the last start
module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 6,
  parameter logic [7:0]  DEV_ADDR    = 8'h34,
  parameter int unsigned MAX_RETRIES = 3,
  parameter bit          AUTO_START  = 1'b1,
  parameter int unsigned IDX_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [IDX_W-1:0]      tbl_idx,
  input  logic [ENTRY_W-1:0]    tbl_entry,
  output logic                  i2c_start,
  output logic [I2C_WORD_W-1:0] i2c_data,
  input  logic                  i2c_done,
  input  logic                  i2c_ack,
  output logic                  busy,
  output logic                  ready,
  output logic                  error,
  output logic [7:0]            nack_count
);

  localparam int unsigned    RETRY_W  = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t                  state, state_nxt;
  logic [RETRY_W-1:0]      retry_cnt, retry_nxt;
  logic                    auto_pend, auto_nxt;
  logic [IDX_W-1:0]        idx_nxt;
  logic                    i2c_start_nxt;
  logic [I2C_WORD_W-1:0]   i2c_data_nxt;
  logic                    busy_nxt, ready_nxt, error_nxt;
  logic [7:0]              nack_nxt;

  // State and registered outputs. auto_pend makes the first clock after
  // reset release look like a start pulse when AUTO_START is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      retry_cnt  <= '0;
      auto_pend  <= AUTO_START;
      tbl_idx    <= '0;
      i2c_start  <= 1'b0;
      i2c_data   <= '0;
      busy       <= 1'b0;
      ready      <= 1'b0;
      error      <= 1'b0;
      nack_count <= '0;
    end else begin
      state      <= state_nxt;
      retry_cnt  <= retry_nxt;
      auto_pend  <= auto_nxt;
      tbl_idx    <= idx_nxt;
      i2c_start  <= i2c_start_nxt;
      i2c_data   <= i2c_data_nxt;
      busy       <= busy_nxt;
      ready      <= ready_nxt;
      error      <= error_nxt;
      nack_count <= nack_nxt;
    end
  end

  // Next-state and next-output logic. i2c_start/i2c_data are computed in
  // SEND so they appear together in the first WAIT cycle.
  always_comb begin
    state_nxt     = state;
    retry_nxt     = retry_cnt;
    auto_nxt      = auto_pend;
    idx_nxt       = tbl_idx;
    i2c_start_nxt = 1'b0;
    i2c_data_nxt  = i2c_data;
    busy_nxt      = busy;
    ready_nxt     = ready;
    error_nxt     = error;
    nack_nxt      = nack_count;

    case (state)
      IDLE: begin
        if (start || auto_pend) begin
          state_nxt = LOAD;
          auto_nxt  = 1'b0;
          ready_nxt = 1'b0;
          error_nxt = 1'b0;
          nack_nxt  = '0;
          idx_nxt   = '0;
          retry_nxt = '0;
          busy_nxt  = 1'b1;
        end
      end
      LOAD: state_nxt = SEND;
      SEND: begin
        i2c_data_nxt  = {DEV_ADDR, tbl_entry};
        i2c_start_nxt = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (i2c_done) begin
          if (i2c_ack) begin
            state_nxt = NEXT;
          end else begin
            if (nack_count != 8'hFF) nack_nxt = nack_count + 8'd1;
            state_nxt = RETRY;
          end
        end
      end
      RETRY: begin
        if (retry_cnt < RETRY_MAX) begin
          retry_nxt = retry_cnt + RETRY_W'(1);
          state_nxt = SEND;
        end else begin
          error_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      NEXT: begin
        retry_nxt = '0;
        if (tbl_idx == LAST_IDX) begin
          ready_nxt = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          idx_nxt   = tbl_idx + IDX_W'(1);
          state_nxt = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Bench for codec_cfg_sequencer: instance A uses the default parameters
// with a configurable NACKing I2C responder, instance B has NUM_REGS=1 and
// AUTO_START=0 with an always-ACK responder. Both read codec_cfg_rom.
module tb_codec_cfg_sequencer;

  localparam logic [23:0] EXP_BASE [6] = '{24'h340804, 24'h340E42, 24'h341201,
                                           24'h340C39, 24'h340017, 24'h340217};
  localparam logic [23:0] EXP_RETRY [8] = '{24'h340804, 24'h340E42, 24'h341201,
                                            24'h341201, 24'h341201, 24'h340C39,
                                            24'h340017, 24'h340217};

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A
  logic        a_start, a_i2c_start, a_done, a_ack, a_busy, a_ready, a_error;
  logic        inj_done, inj_ack, a_done_in, a_ack_in;
  logic [7:0]  a_idx, a_nack;
  logic [15:0] a_entry;
  logic [23:0] a_i2c_data;
  logic [10:0] a_stat;

  assign a_done_in = a_done | inj_done;
  assign a_ack_in  = inj_done ? inj_ack : a_ack;
  assign a_stat    = {a_busy, a_ready, a_error, a_nack};

  codec_cfg_rom #(.IDX_W(8)) rom_a (.idx(a_idx), .entry_c(a_entry));

  codec_cfg_sequencer dut_a (
    .clk(clk), .reset(reset), .start(a_start), .tbl_idx(a_idx),
    .tbl_entry(a_entry), .i2c_start(a_i2c_start), .i2c_data(a_i2c_data),
    .i2c_done(a_done_in), .i2c_ack(a_ack_in), .busy(a_busy),
    .ready(a_ready), .error(a_error), .nack_count(a_nack)
  );

  // Instance B
  logic        b_start, b_i2c_start, b_done, b_ack, b_busy, b_ready, b_error;
  logic [7:0]  b_idx, b_nack;
  logic [15:0] b_entry;
  logic [23:0] b_i2c_data;

  codec_cfg_rom #(.IDX_W(8)) rom_b (.idx(b_idx), .entry_c(b_entry));

  codec_cfg_sequencer #(.NUM_REGS(1), .AUTO_START(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .tbl_idx(b_idx),
    .tbl_entry(b_entry), .i2c_start(b_i2c_start), .i2c_data(b_i2c_data),
    .i2c_done(b_done), .i2c_ack(b_ack), .busy(b_busy),
    .ready(b_ready), .error(b_error), .nack_count(b_nack)
  );

  // I2C responder models: log each i2c_start, answer 4 cycles later
  logic [23:0] a_log[$];
  int          a_st_cyc[$];
  int          a_dn_cyc[$];
  logic [23:0] nack_word = 24'h0;
  int          nack_left = 0;
  int          a_pend;
  logic [23:0] b_log[$];
  int          b_st_cyc[$];
  int          b_pend;

  initial begin
    a_done = 1'b0; a_ack = 1'b0; a_pend = 0;
    forever begin
      @(negedge clk);
      a_done = 1'b0; a_ack = 1'b0;
      if (reset) a_pend = 0;
      else if (a_i2c_start) begin
        a_log.push_back(a_i2c_data); a_st_cyc.push_back(cyc); a_pend = 4;
      end else if (a_pend > 0) begin
        a_pend--;
        if (a_pend == 0) begin
          a_done = 1'b1; a_ack = 1'b1;
          if (a_i2c_data == nack_word && nack_left > 0) begin
            a_ack = 1'b0; nack_left--;
          end
          a_dn_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    b_done = 1'b0; b_ack = 1'b0; b_pend = 0;
    forever begin
      @(negedge clk);
      b_done = 1'b0; b_ack = 1'b0;
      if (reset) b_pend = 0;
      else if (b_i2c_start) begin
        b_log.push_back(b_i2c_data); b_st_cyc.push_back(cyc); b_pend = 4;
      end else if (b_pend > 0) begin
        b_pend--;
        if (b_pend == 0) begin b_done = 1'b1; b_ack = 1'b1; end
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_a_log();
    a_log.delete(); a_st_cyc.delete(); a_dn_cyc.delete();
  endtask

  task automatic pulse_a_start();
    a_start = 1'b1; tick(); a_start = 1'b0;
  endtask

  task automatic wait_a_idle();
    int n = 0;
    while (a_busy && n < 1000) begin tick(); n++; end
    checks++;
    if (a_busy) begin
      errors++; $display("FAIL a_idle_timeout: busy=%b after %0d cycles, required 0", a_busy, n);
    end
  endtask

  task automatic wait_a_log(input int want);
    int n = 0;
    while (a_log.size() < want && n < 1000) begin tick(); n++; end
    checks++;
    if (a_log.size() < want) begin
      errors++; $display("FAIL a_log_timeout: transfers=%0d, required %0d", a_log.size(), want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({a_idx, a_i2c_start, a_i2c_data} !== 33'h0) begin
      errors++; $display("FAIL reset_a_bus: idx=%h start=%b data=%h, required 0", a_idx, a_i2c_start, a_i2c_data);
    end
    checks++;
    if (a_stat !== 11'h0) begin
      errors++; $display("FAIL reset_a_status: %h, required 000", a_stat);
    end
    checks++;
    if ({b_idx, b_i2c_start, b_i2c_data, b_busy, b_ready, b_error, b_nack} !== 44'h0) begin
      errors++; $display("FAIL reset_b: nonzero outputs idx=%h data=%h busy=%b", b_idx, b_i2c_data, b_busy);
    end
  endtask

  task automatic test_auto_run();
    int rel;
    clear_a_log();
    reset = 1'b0; rel = cyc;
    tick();
    wait_a_idle();
    checks++;
    if (a_log.size() != 6) begin
      errors++; $display("FAIL auto_count: transfers=%0d, required 6", a_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (a_log[i] !== EXP_BASE[i]) begin
          errors++; $display("FAIL auto_word%0d: %h, required %h", i, a_log[i], EXP_BASE[i]);
        end
      end
      checks++;
      if (a_st_cyc[0] - rel != 3) begin
        errors++; $display("FAIL auto_latency: %0d cycles, required 3", a_st_cyc[0] - rel);
      end
      for (int k = 1; k < 6; k++) begin
        checks++;
        if (a_st_cyc[k] - a_dn_cyc[k-1] - 1 != 3) begin
          errors++; $display("FAIL gap%0d: %0d idle cycles, required 3", k, a_st_cyc[k] - a_dn_cyc[k-1] - 1);
        end
      end
    end
    checks++;
    if (a_stat !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL auto_status: %h, required 200", a_stat);
    end
  endtask

  task automatic test_done_outside_wait();
    inj_done = 1'b1; inj_ack = 1'b0;
    tick();
    inj_done = 1'b0;
    tick();
    checks++;
    if (a_stat !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL stray_done: status %h, required 200", a_stat);
    end
  endtask

  task automatic test_retry();
    nack_word = 24'h341201; nack_left = 2;
    clear_a_log();
    pulse_a_start();
    wait_a_idle();
    checks++;
    if (a_log.size() != 8) begin
      errors++; $display("FAIL retry_count: transfers=%0d, required 8", a_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (a_log[i] !== EXP_RETRY[i]) begin
          errors++; $display("FAIL retry_word%0d: %h, required %h", i, a_log[i], EXP_RETRY[i]);
        end
      end
    end
    checks++;
    if (a_stat !== {1'b0, 1'b1, 1'b0, 8'd2}) begin
      errors++; $display("FAIL retry_status: %h, required 202", a_stat);
    end
  endtask

  task automatic test_error();
    nack_word = 24'h340804; nack_left = 100;
    clear_a_log();
    pulse_a_start();
    wait_a_idle();
    nack_left = 0;
    checks++;
    if (a_log.size() != 4) begin
      errors++; $display("FAIL error_attempts: %0d, required 4", a_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (a_log[i] !== 24'h340804) begin
          errors++; $display("FAIL error_word%0d: %h, required 340804", i, a_log[i]);
        end
      end
    end
    checks++;
    if (a_stat !== {1'b0, 1'b0, 1'b1, 8'd4}) begin
      errors++; $display("FAIL error_status: %h, required 104", a_stat);
    end
    checks++;
    if (a_idx !== 8'd0) begin
      errors++; $display("FAIL error_idx: %0d, required 0", a_idx);
    end
  endtask

  task automatic test_start_while_busy();
    clear_a_log();
    pulse_a_start();
    wait_a_log(4);
    pulse_a_start();
    checks++;
    if (a_busy !== 1'b1 || a_error !== 1'b0) begin
      errors++; $display("FAIL busy_start_state: busy=%b error=%b, required 1 0", a_busy, a_error);
    end
    wait_a_idle();
    checks++;
    if (a_log.size() != 6 || a_ready !== 1'b1) begin
      errors++; $display("FAIL busy_start_run: transfers=%0d ready=%b, required 6 1", a_log.size(), a_ready);
    end
    clear_a_log();
    pulse_a_start();
    checks++;
    if (a_ready !== 1'b0 || a_busy !== 1'b1) begin
      errors++; $display("FAIL rerun_clear: ready=%b busy=%b, required 0 1", a_ready, a_busy);
    end
    wait_a_idle();
    checks++;
    if (a_log.size() != 6 || a_stat !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL rerun: transfers=%0d status=%h, required 6 200", a_log.size(), a_stat);
    end
  endtask

  task automatic test_reset_mid();
    clear_a_log();
    pulse_a_start();
    wait_a_log(5);
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({a_idx, a_i2c_start, a_i2c_data} !== 33'h0 || a_stat !== 11'h0) begin
      errors++; $display("FAIL mid_reset: idx=%h data=%h status=%h, required 0", a_idx, a_i2c_data, a_stat);
    end
    repeat (3) tick();
    checks++;
    if (a_log.size() != 5) begin
      errors++; $display("FAIL mid_reset_reissue: transfers=%0d, required 5", a_log.size());
    end
    clear_a_log();
    reset = 1'b0;
    tick();
    wait_a_idle();
    checks++;
    if (a_log.size() != 6 || a_log[0] !== 24'h340804) begin
      errors++; $display("FAIL mid_reset_rerun: transfers=%0d first=%h, required 6 340804",
                         a_log.size(), (a_log.size() > 0) ? a_log[0] : 24'h0);
    end
    checks++;
    if (a_stat !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
      errors++; $display("FAIL mid_reset_status: %h, required 200", a_stat);
    end
  endtask

  task automatic test_single();
    int s;
    int n = 0;
    checks++;
    if (b_busy !== 1'b0 || b_ready !== 1'b0 || b_log.size() != 0) begin
      errors++; $display("FAIL single_idle: busy=%b ready=%b transfers=%0d, required 0 0 0", b_busy, b_ready, b_log.size());
    end
    b_start = 1'b1; s = cyc;
    tick();
    b_start = 1'b0;
    while (b_busy && n < 1000) begin tick(); n++; end
    checks++;
    if (b_busy) begin
      errors++; $display("FAIL b_idle_timeout: busy=%b after %0d cycles, required 0", b_busy, n);
    end
    checks++;
    if (b_log.size() != 1 || b_log[0] !== 24'h340804) begin
      errors++; $display("FAIL single_xfer: transfers=%0d first=%h, required 1 340804",
                         b_log.size(), (b_log.size() > 0) ? b_log[0] : 24'h0);
    end else begin
      checks++;
      if (b_st_cyc[0] - s != 3) begin
        errors++; $display("FAIL single_latency: %0d cycles, required 3", b_st_cyc[0] - s);
      end
    end
    checks++;
    if ({b_ready, b_error, b_nack, b_idx} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
      errors++; $display("FAIL single_status: ready=%b error=%b nack=%0d idx=%0d, required 1 0 0 0",
                         b_ready, b_error, b_nack, b_idx);
    end
  endtask

  initial begin
    reset = 1'b1; a_start = 1'b0; b_start = 1'b0; inj_done = 1'b0; inj_ack = 1'b0;
    test_reset();
    test_auto_run();
    test_done_outside_wait();
    test_retry();
    test_error();
    test_start_while_busy();
    test_reset_mid();
    test_single();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
